// File: rtl/i2c_slave_byte_engine_pkg.sv
// Shared I2C definitions: FSM state encoding, line-sync constants and bus condition helpers.
package i2c_slave_byte_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK
  } i2c_state_t;

  // Synchronizer depth and the idle (released) level of an open-drain line.
  localparam int unsigned SYNC_STAGES     = 2;
  localparam logic        LINE_IDLE_LEVEL = 1'b1;

  // Address phase is always 7 address bits plus R/W.
  localparam int unsigned ADDR_BITS = 8;

  // Synchronized line level plus single-cycle edge strobes.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } line_t;

  // START: SDA falls while SCL is high.
  function automatic logic is_start(input logic scl_level, input logic sda_fall);
    return scl_level & sda_fall;
  endfunction

  // STOP: SDA rises while SCL is high.
  function automatic logic is_stop(input logic scl_level, input logic sda_rise);
    return scl_level & sda_rise;
  endfunction

endpackage

// File: rtl/i2c_slave_byte_engine_if.sv
// Bus-side and splitter-side signals of the byte engine.
interface i2c_slave_byte_engine_if #(
  parameter int unsigned I2C_DATA_WIDTH = 8
);
  logic                      scl;
  logic                      sda_in;
  logic                      sda_pull;
  logic [I2C_DATA_WIDTH-1:0] data_in;
  logic                      ready;
  logic [I2C_DATA_WIDTH-1:0] data_out;
  logic                      data_out_valid;

  modport slave (
    input  scl, sda_in, data_in,
    output sda_pull, ready, data_out, data_out_valid
  );

  modport master (
    output scl, sda_in, data_in,
    input  sda_pull, ready, data_out, data_out_valid
  );
endinterface

// File: rtl/i2c_slave_byte_engine_line_sync.sv
// Two-flop synchronizer plus edge detector for one raw I2C line.
module i2c_line_sync
  import i2c_slave_byte_engine_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  line_in,
  output line_t line_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw line through the synchronizer and remember the last synced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE_LEVEL}};
      prev_q <= LINE_IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign line_c.level = sync_q[SYNC_STAGES-1];
  assign line_c.rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign line_c.fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave_byte_engine.sv
// I2C slave byte engine: address match, byte receive to data_out, byte transmit from data_in.
module i2c_slave_byte_engine
  import i2c_slave_byte_engine_pkg::*;
#(
  parameter int unsigned I2C_DATA_WIDTH = 8,
  parameter logic [6:0]  ADDRESS        = 7'h47
) (
  input logic                   clk,
  input logic                   rst,
  i2c_slave_byte_engine_if.slave bus
);

  localparam int unsigned       W        = I2C_DATA_WIDTH;
  localparam int unsigned       CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR = CNT_W'(ADDR_BITS);

  line_t scl_l;
  line_t sda_l;

  i2c_line_sync u_scl_sync (.clk(clk), .rst(rst), .line_in(bus.scl),    .line_c(scl_l));
  i2c_line_sync u_sda_sync (.clk(clk), .rst(rst), .line_in(bus.sda_in), .line_c(sda_l));

  i2c_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic [W-1:0]         sr;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rw;
  logic                 start_c;
  logic                 stop_c;

  assign start_c   = is_start(scl_l.level, sda_l.fall);
  assign stop_c    = is_stop(scl_l.level, sda_l.rise);
  // Bit counter saturates instead of wrapping.
  assign cnt_inc_c = (cnt == CNT_FULL) ? cnt : cnt + CNT_ONE;

  // Protocol FSM: sample SDA on SCL rise, change SDA drive right after SCL fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      cnt                <= CNT_ZERO;
      sr                 <= '0;
      addr_q             <= '0;
      rw                 <= 1'b0;
      bus.sda_pull       <= 1'b0;
      bus.ready          <= 1'b1;
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
    end else begin
      bus.data_out_valid <= 1'b0;
      if (stop_c) begin
        // Any abort returns the splitter handshake to its idle level.
        state        <= ST_IDLE;
        cnt          <= CNT_ZERO;
        bus.sda_pull <= 1'b0;
        bus.ready    <= 1'b1;
      end else if (start_c) begin
        state        <= ST_ADDR;
        cnt          <= CNT_ZERO;
        bus.sda_pull <= 1'b0;
        bus.ready    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            bus.sda_pull <= 1'b0;
          end
          ST_ADDR: begin
            if (scl_l.rise) begin
              addr_q <= {addr_q[ADDR_BITS-2:0], sda_l.level};
              cnt    <= cnt_inc_c;
            end else if (scl_l.fall && cnt == CNT_ADDR) begin
              cnt <= CNT_ZERO;
              if (addr_q[ADDR_BITS-1:1] == ADDRESS) begin
                state        <= ST_ADDR_ACK;
                bus.sda_pull <= 1'b1;
                rw           <= addr_q[0];
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_l.rise) begin
              cnt <= cnt_inc_c;
            end else if (scl_l.fall && cnt == CNT_ONE) begin
              cnt <= CNT_ZERO;
              if (rw) begin
                state        <= ST_TX_BYTE;
                sr           <= bus.data_in;
                bus.ready    <= 1'b0;
                bus.sda_pull <= ~bus.data_in[W-1];
              end else begin
                state        <= ST_RX_BYTE;
                bus.sda_pull <= 1'b0;
              end
            end
          end
          ST_RX_BYTE: begin
            if (scl_l.rise) begin
              sr  <= {sr[W-2:0], sda_l.level};
              cnt <= cnt_inc_c;
              if (cnt == CNT_LAST) begin
                bus.data_out       <= {sr[W-2:0], sda_l.level};
                bus.data_out_valid <= 1'b1;
              end
            end else if (scl_l.fall && cnt == CNT_FULL) begin
              state        <= ST_RX_ACK;
              cnt          <= CNT_ZERO;
              bus.sda_pull <= 1'b1;
            end
          end
          ST_RX_ACK: begin
            if (scl_l.rise) begin
              cnt <= cnt_inc_c;
            end else if (scl_l.fall && cnt == CNT_ONE) begin
              state        <= ST_RX_BYTE;
              cnt          <= CNT_ZERO;
              bus.sda_pull <= 1'b0;
            end
          end
          ST_TX_BYTE: begin
            // The bit on the wire is sr[W-1]; advance once the master has clocked it.
            if (scl_l.rise) begin
              sr  <= {sr[W-2:0], 1'b0};
              cnt <= cnt_inc_c;
            end else if (scl_l.fall) begin
              if (cnt == CNT_FULL) begin
                state        <= ST_TX_ACK;
                cnt          <= CNT_ZERO;
                bus.sda_pull <= 1'b0;
              end else begin
                bus.sda_pull <= ~sr[W-1];
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_l.rise) begin
              bus.ready <= 1'b1;
              cnt       <= cnt_inc_c;
              if (sda_l.level) begin
                state <= ST_IDLE;
                cnt   <= CNT_ZERO;
              end
            end else if (scl_l.fall && cnt == CNT_ONE) begin
              state        <= ST_TX_BYTE;
              cnt          <= CNT_ZERO;
              sr           <= bus.data_in;
              bus.ready    <= 1'b0;
              bus.sda_pull <= ~bus.data_in[W-1];
            end
          end
          default: begin
            state        <= ST_IDLE;
            cnt          <= CNT_ZERO;
            bus.sda_pull <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Bench: bit-level I2C master, word-splitter model on ready, and scoreboard on data_out_valid.
module tb_i2c_slave_byte_engine;

  localparam int unsigned W = 8;
  localparam int unsigned Q = 6;  // clk cycles per quarter SCL period

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_slave_byte_engine_if #(.I2C_DATA_WIDTH(W)) bus ();

  i2c_slave_byte_engine #(.I2C_DATA_WIDTH(W), .ADDRESS(7'h47)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Open-drain bus: low if either side pulls.
  assign bus.scl    = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_pull;

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  tx_src [64];
  int          idx;
  int          exp_ptr  = 0;
  int          rise_cnt = 0;
  logic        ready_prev = 1'b1;
  logic [7:0]  rx_exp [$];
  logic [7:0]  wr_bytes [$];
  logic        mon_track = 1'b0;
  logic        pull_seen = 1'b0;
  logic        ready_low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Splitter model and output monitor, sampled on the inactive edge.
  initial begin
    tx_src[0] = 8'hDE; tx_src[1] = 8'hAD; tx_src[2] = 8'hBE; tx_src[3] = 8'hEF;
    tx_src[4] = 8'hB5; tx_src[5] = 8'h3C;
    for (int i = 6; i < 64; i++) tx_src[i] = 8'($urandom);
    bus.data_in = tx_src[0];
    idx = 1;
    forever begin
      @(negedge clk);
      if (bus.data_out_valid === 1'b1) begin
        if (rx_exp.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
        else check("rx_data", 32'(bus.data_out), 32'(rx_exp.pop_front()));
      end
      if (mon_track) begin
        if (bus.sda_pull !== 1'b0) pull_seen = 1'b1;
        if (bus.ready !== 1'b1) ready_low_seen = 1'b1;
      end
      if (bus.ready === 1'b1 && ready_prev === 1'b0) begin
        rise_cnt++;
        bus.data_in = tx_src[idx % 64];
        idx++;
      end
      ready_prev = bus.ready;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = bus.sda_in; wq(); scl_m = 1'b0; wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(v);
      b[i] = v;
    end
    send_bit(~ack);
  endtask

  task automatic master_write(input logic do_stop);
    logic ack;
    i2c_start();
    write_byte({7'h47, 1'b0}, ack);
    check("addr_ack_wr", 32'(ack), 32'd1);
    foreach (wr_bytes[k]) begin
      rx_exp.push_back(wr_bytes[k]);
      write_byte(wr_bytes[k], ack);
      check("data_ack", 32'(ack), 32'd1);
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic master_read(input int n);
    logic       ack;
    logic [7:0] b;
    logic [7:0] e;
    i2c_start();
    write_byte({7'h47, 1'b1}, ack);
    check("addr_ack_rd", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      e = tx_src[exp_ptr % 64];
      exp_ptr++;
      read_byte(b, k != n - 1);
      check("tx_byte", 32'(b), 32'(e));
    end
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic       v;
    logic [7:0] e;
    int         n;

    repeat (3) @(negedge clk);
    check("rst_sda_pull", 32'(bus.sda_pull), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.data_out_valid), 32'd0);
    rst = 1'b0;
    wq();

    // Four-byte master read; each byte consumed raises ready once.
    rise_cnt = 0;
    master_read(4);
    check("ready_rises", 32'(rise_cnt), 32'd4);

    // Two-byte master write.
    wr_bytes = '{8'h12, 8'h34};
    master_write(1'b1);

    // Foreign address: slave must stay silent.
    pull_seen = 1'b0; ready_low_seen = 1'b0; mon_track = 1'b1;
    i2c_start();
    write_byte({7'h46, 1'b0}, ack);
    check("foreign_addr_nack", 32'(ack), 32'd0);
    write_byte(8'h99, ack);
    check("foreign_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    mon_track = 1'b0;
    check("foreign_no_pull", 32'(pull_seen), 32'd0);
    check("foreign_ready_high", 32'(ready_low_seen), 32'd0);

    // STOP after three bits of a transmitted byte.
    i2c_start();
    write_byte({7'h47, 1'b1}, ack);
    check("addr_ack_rd", 32'(ack), 32'd1);
    e = tx_src[exp_ptr % 64];
    exp_ptr++;
    for (int i = 0; i < 3; i++) begin
      recv_bit(v);
      check("partial_tx_bit", 32'(v), 32'(e[7-i]));
    end
    check("ready_low_in_tx", 32'(bus.ready), 32'd0);
    sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stop_tx_sda_pull", 32'(bus.sda_pull), 32'd0);
    check("stop_tx_ready", 32'(bus.ready), 32'd1);
    wq();

    // Write, repeated START, then read the byte currently presented.
    wr_bytes = '{8'h5A};
    master_write(1'b0);
    master_read(1);

    // Reset in the middle of a received byte, then a clean write.
    i2c_start();
    write_byte({7'h47, 1'b0}, ack);
    check("addr_ack_wr", 32'(ack), 32'd1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sda_pull", 32'(bus.sda_pull), 32'd0);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_valid", 32'(bus.data_out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); wq();
    wr_bytes = '{8'hA7};
    master_write(1'b1);

    // Randomized reads and writes.
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        master_read(n);
      end else begin
        wr_bytes = {};
        for (int k = 0; k < n; k++) wr_bytes.push_back(8'($urandom));
        master_write(1'b1);
      end
      wq();
    end

    for (int t = 0; t < 50 && rx_exp.size() != 0; t++) @(negedge clk);
    check("rx_drained", 32'(rx_exp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_engine.md
I2C_SLAVE_BYTE_ENGINE -- requirements
Module: i2c_slave_byte_engine

Interface
REQ-001 SHALL have parameter I2C_DATA_WIDTH, default 8, byte width on the bus and on data ports.
REQ-002 SHALL have parameter ADDRESS, default 7'h47, 7-bit slave address matched after START.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port scl  input  1  raw bus clock, asynchronous to clk.
REQ-006 SHALL have port sda_in  input  1  raw bus data, asynchronous to clk.
REQ-007 SHALL have port sda_pull  output  1  open-drain drive, 1 = pull SDA low.
REQ-008 SHALL have port data_in  input  I2C_DATA_WIDTH  next byte to transmit, fed by the word splitter.
REQ-009 SHALL have port ready  output  1  level handshake to the splitter; a 0->1 transition means "byte consumed, present next".
REQ-010 SHALL have port data_out  output  I2C_DATA_WIDTH  last byte received in a master-write.
REQ-011 SHALL have port data_out_valid  output  1  one-cycle pulse when data_out updates.

Function
REQ-012 SHALL pass scl and sda_in through 2-FF synchronizers; edge detection uses the synchronized values only.
REQ-013 SHALL detect START as synced SDA 1->0 while synced SCL = 1, and STOP as SDA 0->1 while SCL = 1, in any state.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
REQ-015 SHALL sample SDA on synced SCL rising edges and change sda_pull only on the clk cycle after a synced SCL falling edge.
REQ-016 SHALL in IDLE hold sda_pull = 0; START -> ADDR with bit counter cleared.
REQ-017 SHALL in ADDR shift 8 bits MSB-first; on match of the upper 7 bits with ADDRESS -> ADDR_ACK; on mismatch -> IDLE.
REQ-018 SHALL in ADDR_ACK pull SDA low for one SCL period, then go to TX_BYTE if R/W = 1, else RX_BYTE.
REQ-019 SHALL on entry to TX_BYTE latch data_in into the shift register and drive ready to 0 on that same cycle.
REQ-020 SHALL in TX_BYTE drive sda_pull = ~bit, MSB first, for I2C_DATA_WIDTH bits, then release SDA and go to TX_ACK.
REQ-021 SHALL in TX_ACK raise ready to 1 on the 9th SCL rising edge, regardless of ACK/NACK.
REQ-022 SHALL in TX_ACK go to TX_BYTE (relatch data_in) on the next SCL falling edge if ACK (SDA = 0) was sampled; on NACK go to IDLE with ready = 1.
REQ-023 SHALL keep ready = 1 for at least 2 clk cycles before the next latch; clk must exceed 8x the SCL frequency.
REQ-024 SHALL in RX_BYTE shift in I2C_DATA_WIDTH bits; after the last bit update data_out, pulse data_out_valid for 1 clk, and go to RX_ACK.
REQ-025 SHALL in RX_ACK pull SDA low for one SCL period, then return to RX_BYTE.
REQ-026 SHALL on START in any non-IDLE state (repeated START) go to ADDR with sda_pull released on the same cycle.
REQ-027 SHALL on STOP in any state go to IDLE with sda_pull = 0; if STOP arrives mid-TX_BYTE, set ready = 1.
REQ-028 SHALL use a $clog2(I2C_DATA_WIDTH+1)-bit bit counter that never wraps; it is cleared on every state entry.

Reset
REQ-029 SHALL on rst = 1 set state IDLE, sda_pull = 0, ready = 1, data_out = 0, data_out_valid = 0, counters and shift registers 0, and synchronizers to 1.
REQ-030 SHALL let a reset asserted mid-transaction abort it; the next transaction begins only at a fresh START.

Structure
REQ-031 SHALL place the state encoding and the START/STOP/edge-detect constants in a shared i2c package used by the other i2c blocks.
REQ-032 SHALL implement the synchronizer and edge detector as sub-module i2c_line_sync, instantiated once per line.

Verification
REQ-033 Master read at 0x47, 4 bytes, data_in sequence 0xDE,0xAD,0xBE,0xEF -> SDA carries those bytes MSB-first; ready shows 4 rising edges; final NACK -> IDLE.
REQ-034 Master write at 0x47, bytes 0x12,0x34 -> data_out_valid pulses twice with 0x12 then 0x34; slave ACKs the address and both bytes.
REQ-035 Address 0x46 -> sda_pull stays 0 for the whole transaction; ready stays 1.
REQ-036 STOP after 3 bits of a TX byte -> IDLE within 3 clk; sda_pull = 0; ready = 1.
REQ-037 Repeated START after a write, then read -> ADDR re-entered; first TX byte is latched from the current data_in.
REQ-038 rst pulse during RX_BYTE -> all outputs at reset values next cycle; a following valid write is received correctly.
